// File: rtl/instr_prefetch_queue.sv
// Fetch stage in front of the instruction ROM: PC, one-deep request tracking, response FIFO to decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instr_prefetch_queue #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned RESET_PC     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      IMEM_ENABLE,
  output logic [ADDRESS_SIZE-1:0]   IMEM_ADDRESS,
  input  logic [WORD_SIZE-1:0]      IMEM_DATA,
  input  logic                      IMEM_DATA_READY,
  input  logic                      REDIRECT,
  input  logic [ADDRESS_SIZE-1:0]   REDIRECT_PC,
  output logic [WORD_SIZE-1:0]      INSTR,
  output logic [ADDRESS_SIZE-1:0]   INSTR_PC,
  output logic                      INSTR_VALID,
  input  logic                      INSTR_READY,
  output logic [$clog2(DEPTH):0]    COUNT
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;
  localparam int unsigned PC_INC = WORD_SIZE / 8;

  typedef enum logic {S_RUN, S_DRAIN} state_t;
  state_t state, state_next;

  logic [ADDRESS_SIZE-1:0] pc, pc_next, req_pc;
  logic                    inflight, inflight_next;
  logic [WORD_SIZE-1:0]    data_mem [DEPTH];
  logic [ADDRESS_SIZE-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    issue, resp, flush, push, pop, head_valid, bypass;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Next state, request issue and PC update
  always_comb begin
    state_next    = state;
    inflight_next = inflight;
    pc_next       = pc;
    issue         = 1'b0;
    resp          = 1'b0;
    flush         = 1'b0;
    case (state)
      S_RUN: begin
        issue = !REDIRECT && ((OCC_W'(count) + OCC_W'(inflight)) < OCC_W'(DEPTH));
        resp  = inflight && IMEM_DATA_READY && !REDIRECT;
        if (REDIRECT) begin
          flush = 1'b1;
          // The outstanding word is still owed by the ROM; absorb it in S_DRAIN.
          if (inflight) state_next = S_DRAIN;
        end else if (issue) begin
          inflight_next = 1'b1;
        end else if (resp) begin
          inflight_next = 1'b0;
        end
      end
      S_DRAIN: begin
        flush         = REDIRECT;
        inflight_next = 1'b0;
        state_next    = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
    if (REDIRECT)   pc_next = REDIRECT_PC;
    else if (issue) pc_next = pc + ADDRESS_SIZE'(PC_INC);
  end

  // Decode-side view of the queue head, optionally bypassing an empty FIFO
  always_comb begin
    head_valid = (count != '0);
    bypass     = 1'b0;
`ifdef IFQ_BYPASS_EN
    bypass     = !head_valid && resp;
`endif
    INSTR_VALID = !REDIRECT && (head_valid || bypass);
    INSTR       = bypass ? IMEM_DATA : data_mem[rd_ptr];
    INSTR_PC    = bypass ? req_pc    : pc_mem[rd_ptr];
    pop         = head_valid && INSTR_READY && !REDIRECT;
    push        = resp && !(bypass && INSTR_READY);
  end

  assign IMEM_ENABLE  = issue && !rst;
  assign IMEM_ADDRESS = pc;
  assign COUNT        = count;

  // PC and request tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= ADDRESS_SIZE'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      pc       <= pc_next;
      inflight <= inflight_next;
      if (issue) req_pc <= pc;
    end
  end

  // Response FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem[PTR_W'(i)] <= '0;
        pc_mem[PTR_W'(i)]   <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= IMEM_DATA;
        pc_mem[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Fetch-side stage directly upstream of the instruction ROM. Holds the program counter, issues word requests on the ROM memory interface, captures returned instructions into a small FIFO, and presents them to decode with a valid/ready handshake. Supports branch redirect with discard of the in-flight response.

## Interface
- WORD_SIZE, 32, instruction width in bits
- ADDRESS_SIZE, 16, PC / memory address width in bits
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- IMEM_ENABLE  out  1  ROM request strobe, one word per cycle when high
- IMEM_ADDRESS  out  ADDRESS_SIZE  request address (current PC)
- IMEM_DATA  in  WORD_SIZE  ROM read data
- IMEM_DATA_READY  in  1  ROM response valid
- REDIRECT  in  1  load new PC, flush queue and in-flight response
- REDIRECT_PC  in  ADDRESS_SIZE  target PC
- INSTR  out  WORD_SIZE  head-of-queue instruction
- INSTR_PC  out  ADDRESS_SIZE  PC of INSTR
- INSTR_VALID  out  1  INSTR/INSTR_PC valid
- INSTR_READY  in  1  decode accepts head
- COUNT  out  log2(DEPTH)+1  current FIFO occupancy

## Operation
- FSM states: S_RUN, S_DRAIN. Reset → S_RUN.
- Issue: IMEM_ENABLE = (state==S_RUN) && !REDIRECT && (COUNT + inflight < DEPTH); no credit taken for a same-cycle dequeue. On issue, PC ← PC + WORD_SIZE/8 (mod 2^ADDRESS_SIZE, wraps silently); inflight ← 1, request PC recorded.
- ROM latency is fixed one cycle: request at edge N returns with IMEM_DATA_READY high during cycle N+1; inflight ≤ 1. Response with inflight==1 is written to tail with its recorded PC; IMEM_DATA_READY with inflight==0 is ignored.
- Dequeue: INSTR_VALID && INSTR_READY at edge pops head. Enqueue and dequeue in same cycle keep COUNT unchanged.
- Redirect (S_RUN): at edge, PC ← REDIRECT_PC, FIFO emptied, COUNT ← 0; if a request is in flight, → S_DRAIN, else stay S_RUN. INSTR_VALID forced 0 while REDIRECT high; no pop occurs.
- S_DRAIN: IMEM_ENABLE 0; response arriving this cycle discarded; inflight ← 0; → S_RUN next edge. REDIRECT in S_DRAIN reloads PC, stays on same transition.
- FIFO never overflows by construction; overflow is an assertion failure.

## Timing
- Reset values: IMEM_ENABLE 0, IMEM_ADDRESS RESET_PC, INSTR_VALID 0, INSTR 0, INSTR_PC 0, COUNT 0, inflight 0.
- First IMEM_ENABLE in first cycle after rst deasserts; first INSTR_VALID two cycles after rst deasserts (one with bypass, see Configuration).
- Sustained throughput one instruction per cycle with INSTR_READY held high and DEPTH ≥ 2.
- Redirect penalty: first instruction from target valid two cycles after the REDIRECT edge if nothing in flight, three if draining.
- rst asserted mid-operation: all state cleared immediately, in-flight response lost.

## Configuration
- IFQ_BYPASS_EN defined: when FIFO is empty and a valid (non-discarded) response arrives, INSTR/INSTR_PC/INSTR_VALID are driven combinationally from IMEM_DATA and recorded PC in that cycle; if INSTR_READY is high it is consumed without being written; otherwise it is written normally. Saves one cycle of fetch latency.
- Undefined: INSTR_VALID only from registered FIFO head; all outputs registered-path only.

## Test plan
- Reset release, RESET_PC=0, INSTR_READY=1, ROM words k at address 4k → INSTR_PC 0,4,8,12… one per cycle, INSTR matches, COUNT ≤ 2.
- INSTR_READY held 0 for 10 cycles → exactly 4 entries (PCs 0,4,8,12), IMEM_ENABLE low once COUNT+inflight=4; release → PCs 16,… follow with no gap or duplicate.
- REDIRECT to 0x0100 with request in flight → S_DRAIN one cycle, in-flight word never visible, next INSTR_PC 0x0100, then 0x0104.
- REDIRECT coincident with INSTR_VALID && INSTR_READY → no pop, queue empty, COUNT 0 next cycle.
- PC at 0xFFFC issued → next request address 0x0000.
- rst pulse mid-stream with COUNT=3 → outputs at reset values asynchronously; fetch restarts at RESET_PC; with IFQ_BYPASS_EN first INSTR_VALID one cycle earlier.
